// File: rtl/video_raster_timing_gen_pkg.sv
// Shared raster geometry, flag types and decode helpers for the video timing slice.
// LED/font judges import this to size their HCTR/VCTR inputs.
package video_raster_timing_gen_pkg;

  localparam int CTR_W   = 9;
  localparam int FRAME_W = 8;
  localparam int VCTR_W  = 8;

  localparam int H_TOTAL  = 394;
  localparam int H_ACT    = 320;
  localparam int HS_START = 337;
  localparam int HS_WIDTH = 29;
  localparam int V_TOTAL  = 262;
  localparam int V_ACT    = 240;
  localparam int VS_START = 243;
  localparam int VS_WIDTH = 3;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic csync;
    logic de;
    logic sol;
    logic sof;
  } flags_t;

  // Window edges kept at 10 bits so START+WIDTH cannot overflow a 9-bit counter.
  typedef struct packed {
    logic [9:0] h_act;
    logic [9:0] hs_lo;
    logic [9:0] hs_hi;
    logic [9:0] v_act;
    logic [9:0] vs_lo;
    logic [9:0] vs_hi;
  } bounds_t;

  function automatic flags_t decode_flags(input logic [CTR_W-1:0] h,
                                          input logic [CTR_W-1:0] v,
                                          input bounds_t b);
    logic [9:0] h10;
    logic [9:0] v10;
    flags_t f;
    h10     = {1'b0, h};
    v10     = {1'b0, v};
    f.hsync = (h10 >= b.hs_lo) && (h10 < b.hs_hi);
    f.vsync = (v10 >= b.vs_lo) && (v10 < b.vs_hi);
    f.csync = f.vsync ? ~f.hsync : f.hsync;
    f.de    = (h10 < b.h_act) && (v10 < b.v_act);
    f.sol   = (h == '0);
    f.sof   = (h == '0) && (v == '0);
    return f;
  endfunction

  // Lines past 255 pin to 255 so they never alias an active line index.
  function automatic logic [VCTR_W-1:0] sat_line(input logic [CTR_W-1:0] v);
    return v[CTR_W-1] ? {VCTR_W{1'b1}} : v[VCTR_W-1:0];
  endfunction

endpackage

// File: rtl/video_raster_timing_gen_if.sv
// Pixel-enable/restart inputs and the registered raster outputs of the timing generator.
interface video_raster_timing_gen_if;
  import video_raster_timing_gen_pkg::*;

  logic                CK_EE_i;
  logic                FRAME_RST_i;
  logic [CTR_W-1:0]    HCTRs_o;
  logic [VCTR_W-1:0]   VCTRs_o;
  logic [CTR_W-1:0]    VLINEs_o;
  logic                HSYNC_o;
  logic                VSYNC_o;
  logic                CSYNC_o;
  logic                DE_o;
  logic                SOL_o;
  logic                SOF_o;
  logic [FRAME_W-1:0]  FRAME_CTRs_o;

  modport master (
    input  CK_EE_i, FRAME_RST_i,
    output HCTRs_o, VCTRs_o, VLINEs_o, HSYNC_o, VSYNC_o, CSYNC_o,
           DE_o, SOL_o, SOF_o, FRAME_CTRs_o
  );

  modport slave (
    output CK_EE_i, FRAME_RST_i,
    input  HCTRs_o, VCTRs_o, VLINEs_o, HSYNC_o, VSYNC_o, CSYNC_o,
           DE_o, SOL_o, SOF_o, FRAME_CTRs_o
  );
endinterface

// File: rtl/video_raster_timing_gen_mod_ctr.sv
// Modulo-N counter with enable, synchronous clear (priority) and a wrap carry.
// count_next is exposed so flag decode can be registered alongside the count.
module video_raster_timing_gen_mod_ctr #(
  parameter int WIDTH  = 9,
  parameter int MODULO = 394
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_reg;

  always_comb begin
    wrap       = en & ~clr & (count_reg == LAST);
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = wrap ? '0 : count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/video_raster_timing_gen.sv
// Raster counters and syncs for the video pipe; one pixel per CK_EE_i enable.
// Flags decode the next-state counters and register with them, so all outputs are coherent.
module video_raster_timing_gen
  import video_raster_timing_gen_pkg::*;
#(
  parameter int C_H_TOTAL  = H_TOTAL,
  parameter int C_H_ACT    = H_ACT,
  parameter int C_HS_START = HS_START,
  parameter int C_HS_WIDTH = HS_WIDTH,
  parameter int C_V_TOTAL  = V_TOTAL,
  parameter int C_V_ACT    = V_ACT,
  parameter int C_VS_START = VS_START,
  parameter int C_VS_WIDTH = VS_WIDTH
) (
  input logic                       CK_i,
  input logic                       XARST_i,
  video_raster_timing_gen_if.master vid
);
  localparam bounds_t BOUNDS = '{
    h_act: 10'(C_H_ACT),
    hs_lo: 10'(C_HS_START),
    hs_hi: 10'(C_HS_START + C_HS_WIDTH),
    v_act: 10'(C_V_ACT),
    vs_lo: 10'(C_VS_START),
    vs_hi: 10'(C_VS_START + C_VS_WIDTH)
  };

  logic               ce;
  logic               frame_rst;
  logic               started_reg;
  logic               h_en, h_clr, h_wrap;
  logic               v_en, v_wrap;
  logic               f_en;
  logic               f_wrap_unused;
  logic [CTR_W-1:0]   h_count, h_next;
  logic [CTR_W-1:0]   v_count, v_next;
  logic [FRAME_W-1:0] f_count, f_next_unused;
  flags_t             flags_next, flags_reg;
  logic [VCTR_W-1:0]  vctr_next, vctr_reg;

  assign ce        = vid.CK_EE_i;
  assign frame_rst = vid.FRAME_RST_i;

  // The first enable after reset only presents (0,0); counting starts on the next one.
  assign h_en  = ce & started_reg;
  assign h_clr = ce & frame_rst;
  assign v_en  = h_en & h_wrap;
  assign f_en  = (v_en & v_wrap) | h_clr;

  video_raster_timing_gen_mod_ctr #(.WIDTH(CTR_W), .MODULO(C_H_TOTAL)) u_h_ctr (
    .clk        (CK_i),
    .rst_n      (XARST_i),
    .en         (h_en),
    .clr        (h_clr),
    .count      (h_count),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  video_raster_timing_gen_mod_ctr #(.WIDTH(CTR_W), .MODULO(C_V_TOTAL)) u_v_ctr (
    .clk        (CK_i),
    .rst_n      (XARST_i),
    .en         (v_en),
    .clr        (h_clr),
    .count      (v_count),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  video_raster_timing_gen_mod_ctr #(.WIDTH(FRAME_W), .MODULO(1 << FRAME_W)) u_f_ctr (
    .clk        (CK_i),
    .rst_n      (XARST_i),
    .en         (f_en),
    .clr        (1'b0),
    .count      (f_count),
    .count_next (f_next_unused),
    .wrap       (f_wrap_unused)
  );

  always_comb begin
    flags_next = decode_flags(h_next, v_next, BOUNDS);
    vctr_next  = sat_line(v_next);
  end

  // Flags load only on enable, so pulses hold across CK_EE_i=0 cycles.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      started_reg <= 1'b0;
      flags_reg   <= '0;
      vctr_reg    <= '0;
    end else if (ce) begin
      started_reg <= 1'b1;
      flags_reg   <= flags_next;
      vctr_reg    <= vctr_next;
    end
  end

  assign vid.HCTRs_o      = h_count;
  assign vid.VLINEs_o     = v_count;
  assign vid.VCTRs_o      = vctr_reg;
  assign vid.FRAME_CTRs_o = f_count;
  assign vid.HSYNC_o      = flags_reg.hsync;
  assign vid.VSYNC_o      = flags_reg.vsync;
  assign vid.CSYNC_o      = flags_reg.csync;
  assign vid.DE_o         = flags_reg.de;
  assign vid.SOL_o        = flags_reg.sol;
  assign vid.SOF_o        = flags_reg.sof;
endmodule

// File: tb/tb_video_raster_timing_gen.sv
// Bench: a default-geometry instance plus a short-line instance (full fields fit the cycle budget),
// both driven identically and checked against a linear-pixel-index reference model.
module tb_video_raster_timing_gen;
  import video_raster_timing_gen_pkg::*;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] vline;
    logic [7:0] vctr;
    logic       hs;
    logic       vs;
    logic       cs;
    logic       de;
    logic       sol;
    logic       sof;
    logic [7:0] frame;
  } out_t;

  typedef struct {
    int h_total, h_act, hs_start, hs_width, v_total, v_act, vs_start, vs_width;
  } cfg_t;

  typedef struct {
    logic ce;
    logic fr;
    int   h;
    int   v;
    logic sol;
    logic sof;
    logic de;
    int   frame;
  } vec_t;

  logic CK_i    = 1'b0;
  logic XARST_i = 1'b0;
  always #5 CK_i = ~CK_i;

  video_raster_timing_gen_if if_a ();
  video_raster_timing_gen_if if_b ();

  video_raster_timing_gen dut_a (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .vid     (if_a)
  );

  video_raster_timing_gen #(
    .C_H_TOTAL(40), .C_H_ACT(32), .C_HS_START(34), .C_HS_WIDTH(3)
  ) dut_b (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .vid     (if_b)
  );

  out_t act [2];
  assign act[0] = {if_a.HCTRs_o, if_a.VLINEs_o, if_a.VCTRs_o, if_a.HSYNC_o, if_a.VSYNC_o,
                   if_a.CSYNC_o, if_a.DE_o, if_a.SOL_o, if_a.SOF_o, if_a.FRAME_CTRs_o};
  assign act[1] = {if_b.HCTRs_o, if_b.VLINEs_o, if_b.VCTRs_o, if_b.HSYNC_o, if_b.VSYNC_o,
                   if_b.CSYNC_o, if_b.DE_o, if_b.SOL_o, if_b.SOF_o, if_b.FRAME_CTRs_o};

  int   n_cmp = 0;
  int   n_bad = 0;
  cfg_t cfg [2];
  int   m_p [2];
  int   m_frame [2];
  bit   m_started [2];
  out_t m_exp [2];

  // Reference: position is a linear pixel index within the field.
  function automatic out_t compose(input cfg_t c, input int p, input int fr);
    out_t o;
    int h, v;
    h       = p % c.h_total;
    v       = p / c.h_total;
    o.h     = 9'(h);
    o.vline = 9'(v);
    o.vctr  = (v > 255) ? 8'd255 : 8'(v);
    o.hs    = (h >= c.hs_start) && (h < c.hs_start + c.hs_width);
    o.vs    = (v >= c.vs_start) && (v < c.vs_start + c.vs_width);
    o.cs    = o.vs ? !o.hs : o.hs;
    o.de    = (h < c.h_act) && (v < c.v_act);
    o.sol   = (h == 0);
    o.sof   = (p == 0);
    o.frame = 8'(fr);
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_p[i] = 0; m_frame[i] = 0; m_started[i] = 0; m_exp[i] = '0;
    end
  endtask

  task automatic model_clock(input logic ce, input logic fr);
    if (ce) begin
      for (int i = 0; i < 2; i++) begin
        if (fr) begin
          m_p[i] = 0;
          m_frame[i] = (m_frame[i] + 1) % 256;
        end else if (!m_started[i]) begin
          m_p[i] = 0;
        end else begin
          m_p[i]++;
          if (m_p[i] == cfg[i].h_total * cfg[i].v_total) begin
            m_p[i] = 0;
            m_frame[i] = (m_frame[i] + 1) % 256;
          end
        end
        m_started[i] = 1;
        m_exp[i] = compose(cfg[i], m_p[i], m_frame[i]);
      end
    end
  endtask

  task automatic report(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // Called just after a falling edge: drive, clock, advance model, check on next falling edge.
  task automatic step(input logic ce, input logic fr);
    if_a.CK_EE_i = ce; if_a.FRAME_RST_i = fr;
    if_b.CK_EE_i = ce; if_b.FRAME_RST_i = fr;
    @(posedge CK_i);
    model_clock(ce, fr);
    @(negedge CK_i);
    report("model_a", act[0], m_exp[0]);
    report("model_b", act[1], m_exp[1]);
  endtask

  vec_t vecs [10];
  int   sof_b, wraps, guard, pa, pb;
  logic [7:0] prev_frame;

  initial begin
    cfg[0] = '{394, 320, 337, 29, 262, 240, 243, 3};
    cfg[1] = '{40, 32, 34, 3, 262, 240, 243, 3};
    //          ce    fr    h  v  sol   sof   de    frame
    vecs[0] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 0};
    vecs[2] = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1};
    vecs[6] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1};
    vecs[7] = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1};
    vecs[8] = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1};
    vecs[9] = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 1};

    if_a.CK_EE_i = 1'b0; if_a.FRAME_RST_i = 1'b0;
    if_b.CK_EE_i = 1'b0; if_b.FRAME_RST_i = 1'b0;
    model_reset();
    repeat (3) @(negedge CK_i);
    report("reset_a", act[0], '0);
    report("reset_b", act[1], '0);
    XARST_i = 1'b1;

    // Table: release, first presentation, hold, restart, pulse hold.
    for (int k = 0; k < 10; k++) begin
      step(vecs[k].ce, vecs[k].fr);
      report($sformatf("vec%0d", k),
             {act[0].h, act[0].vline, act[0].sol, act[0].sof, act[0].de, act[0].frame},
             {9'(vecs[k].h), 9'(vecs[k].v), vecs[k].sol, vecs[k].sof, vecs[k].de, 8'(vecs[k].frame)});
    end

    // One full field of the short-line instance with the enable held high.
    sof_b = 0;
    for (int n = 0; n < 40 * 262; n++) begin
      step(1'b1, 1'b0);
      if (act[1].sof) sof_b++;
      pa = m_p[0];
      pb = m_p[1];
      case (pa)
        319: report("a_de_319", act[0].de, 1);
        320: report("a_de_320", act[0].de, 0);
        336: report("a_hs_336", act[0].hs, 0);
        337: report("a_hs_337", act[0].hs, 1);
        365: report("a_hs_365", act[0].hs, 1);
        366: report("a_hs_366", act[0].hs, 0);
        393: report("a_h_393", act[0].h, 393);
        394: report("a_hwrap", {act[0].h, act[0].vline, act[0].sol}, {9'd0, 9'd1, 1'b1});
        default: ;
      endcase
      if (pb % 40 == 0) begin
        case (pb / 40)
          0:   report("b_line0", {act[1].vctr, act[1].sof}, {8'd0, 1'b1});
          240: report("b_vctr_240", act[1].vctr, 240);
          243: report("b_vs_243", {act[1].vs, act[1].cs}, {1'b1, 1'b1});
          245: report("b_vs_245", act[1].vs, 1);
          246: report("b_vs_246", {act[1].vs, act[1].cs}, {1'b0, 1'b0});
          255: report("b_vctr_255", act[1].vctr, 255);
          261: report("b_vctr_261", act[1].vctr, 255);
          default: ;
        endcase
      end
      if (pb == 243 * 40 + 34) report("b_cs_inv", {act[1].hs, act[1].cs}, {1'b1, 1'b0});
      if (pb == 246 * 40 + 34) report("b_cs_norm", {act[1].hs, act[1].cs}, {1'b1, 1'b1});
    end
    report("b_sof_per_field", sof_b, 1);

    // Randomised enable gating with occasional restarts.
    for (int n = 0; n < 3000; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0));

    // 256 restarts walk the field counter once around its 8-bit range.
    wraps = 0;
    for (int n = 0; n < 256; n++) begin
      prev_frame = act[0].frame;
      step(1'b1, 1'b1);
      if (prev_frame == 8'd255 && act[0].frame == 8'd0) wraps++;
    end
    report("a_frame_wraps", wraps, 1);

    // Asynchronous reset in the middle of HSYNC.
    guard = 0;
    while ((m_p[0] % 394) != 340 && guard < 400) begin
      step(1'b1, 1'b0);
      guard++;
    end
    report("a_hs_at_340", {act[0].h, act[0].hs}, {9'd340, 1'b1});
    #1 XARST_i = 1'b0;
    #1;
    report("a_async_rst", act[0], '0);
    report("b_async_rst", act[1], '0);
    model_reset();
    @(negedge CK_i);
    @(negedge CK_i);
    report("a_rst_hold", act[0], '0);
    XARST_i = 1'b1;
    step(1'b1, 1'b0);
    report("a_post_rst", {act[0].h, act[0].vline, act[0].sol, act[0].sof, act[0].de, act[0].frame},
           {9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 8'd0});
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
